// File: rtl/gry_ptr_sync.sv
// Receive-side gray pointer synchroniser: brings a remote gray pointer into clk,
// decodes it to binary and reports advance distance, change pulse and direction errors.
module gry_ptr_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] gry_cnt_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] gry_cnt_sync,
    output logic [WIDTH-1:0] bin_cnt,
    output logic [WIDTH-1:0] delta,
    output logic             inc,
    output logic             dir_err
);

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] bin_q, bin_d, delta_q, delta_d;
    logic             inc_q, inc_d, err_q, err_d;

    // Plain flop chain; any logic between stages would defeat metastability settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= rst_val;
        end else begin
            sync_q[0] <= gry_cnt_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        bin_d   = g2b(sync_q[SYNC_STAGES-1]);
        delta_d = bin_d - bin_q;
        inc_d   = (bin_d != bin_q);
        // A set in the same cycle as a clear keeps the flag raised.
        err_d   = (inc_d && delta_d[WIDTH-1]) || (err_q && !clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= g2b(rst_val);
            delta_q <= '0;
            inc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            delta_q <= delta_d;
            inc_q   <= inc_d;
            err_q   <= err_d;
        end
    end

    assign gry_cnt_sync = sync_q[SYNC_STAGES-1];
    assign bin_cnt      = bin_q;
    assign delta        = delta_q;
    assign inc          = inc_q;
    assign dir_err      = err_q;

endmodule

// File: tb/tb_gry_ptr_sync.sv
// Directed bench for gry_ptr_sync with a history-based reference model and per-cycle compare.
module tb_gry_ptr_sync;
    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] rst_val, gry_cnt_in;
    logic         clr_err;
    logic [W-1:0] gry_cnt_sync, bin_cnt, delta;
    logic         inc, dir_err;

    int vecs = 0;
    int errs = 0;

    gry_ptr_sync #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .rst_val(rst_val), .gry_cnt_in(gry_cnt_in),
        .clr_err(clr_err), .gry_cnt_sync(gry_cnt_sync), .bin_cnt(bin_cnt),
        .delta(delta), .inc(inc), .dir_err(dir_err)
    );

    always #5 clk = ~clk;

    // Decode by searching for the binary value whose gray image matches.
    function automatic int gdec(input logic [W-1:0] g);
        for (int b = 0; b < (1 << W); b++)
            if (((b ^ (b >> 1)) & ((1 << W) - 1)) == int'(g)) return b;
        return -1;
    endfunction

    // hist[0] is the newest sampled input; index S-1 is the synchroniser output,
    // S is what bin_cnt holds and S+1 is the previous bin_cnt.
    logic [W-1:0] hist [0:S+1];
    logic         m_err;

    function automatic int m_bin();   return gdec(hist[S]); endfunction
    function automatic int m_delta(); return (gdec(hist[S]) - gdec(hist[S+1])) & ((1 << W) - 1); endfunction
    function automatic bit m_inc();   return gdec(hist[S]) != gdec(hist[S+1]); endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= S + 1; i++) hist[i] = rst_val;
            m_err = 1'b0;
        end else begin
            for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = gry_cnt_in;
            if (m_inc() && m_delta() >= (1 << (W - 1))) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("sync",  int'(gry_cnt_sync), int'(hist[S-1]));
        chk("bin",   int'(bin_cnt),      m_bin());
        chk("delta", int'(delta),        m_delta());
        chk("inc",   int'(inc),          int'(m_inc()));
        chk("err",   int'(dir_err),      int'(m_err));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        clr_err = 1'b0;
        rst_val = 8'h0C; gry_cnt_in = 8'h0C; rst_n = 1'b0;
        tick(2);
        chk("rst_bin", bin_cnt, 8'h08);
        chk("rst_sync", gry_cnt_sync, 8'h0C);
        chk("rst_delta", delta, 0);
        chk("rst_inc", inc, 0);
        chk("rst_err", dir_err, 0);
        rst_n = 1'b1;
        tick(4);
        chk("rel_inc", inc, 0);
        chk("rel_bin", bin_cnt, 8'h08);

        // latency, multi-step jump, backward moves, clear vs set
        rst_val = 8'h00; gry_cnt_in = 8'h00; rst_n = 1'b0;
        tick(1); rst_n = 1'b1; tick(2);
        gry_cnt_in = 8'h01; tick(2);
        chk("lat_early_inc", inc, 0);
        tick(1);
        chk("lat_bin", bin_cnt, 1);
        chk("lat_delta", delta, 1);
        chk("lat_inc", inc, 1);
        tick(1);
        chk("lat_inc_drop", inc, 0);
        gry_cnt_in = 8'h06; tick(3);
        chk("jump_delta", delta, 3);
        chk("jump_inc", inc, 1);
        chk("jump_err", dir_err, 0);
        tick(1);
        gry_cnt_in = 8'h02; tick(3);
        chk("back_delta", delta, 8'hFF);
        chk("back_err", dir_err, 1);
        tick(1);
        chk("back_sticky", dir_err, 1);
        gry_cnt_in = 8'h01; tick(2);
        clr_err = 1'b1; tick(1);
        chk("setwins_err", dir_err, 1);
        chk("setwins_delta", delta, 8'hFE);
        tick(1);
        chk("clr_err", dir_err, 0);
        clr_err = 1'b0;
        tick(2);

        // wrap, back-to-back advance, reset mid-stream
        rst_val = 8'h80; gry_cnt_in = 8'h80; rst_n = 1'b0;
        tick(1);
        chk("rst80_bin", bin_cnt, 8'hFF);
        rst_n = 1'b1; tick(2);
        gry_cnt_in = 8'h00; tick(3);
        chk("wrap_bin", bin_cnt, 0);
        chk("wrap_delta", delta, 1);
        chk("wrap_err", dir_err, 0);
        for (int v = 1; v <= 12; v++) begin
            gry_cnt_in = W'(v ^ (v >> 1));
            tick(1);
        end
        chk("stream_inc", inc, 1);
        chk("stream_bin", bin_cnt, 10);
        rst_n = 1'b0; #1;
        chk("mid_bin", bin_cnt, 8'hFF);
        chk("mid_sync", gry_cnt_sync, 8'h80);
        chk("mid_delta", delta, 0);
        chk("mid_inc", inc, 0);
        chk("mid_err", dir_err, 0);
        gry_cnt_in = 8'h80; tick(2);
        rst_n = 1'b1; tick(5);
        chk("mid_rel_inc", inc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
